alu_bist: RTL

Built-in self-test sequencer that drives the ALU's operand, command and enable inputs and observes its 16-bit result. It sweeps operands a and b over 0..2^OPW−1 and all 16 commands, compressing every result into a 16-bit MISR signature. It optionally runs a directed enable-low/enable-high check, then reports pass/fail against a golden signature. It sits beside the ALU as the initiator end of the ALU port bundle and replaces the manual exhaustive sweep for on-chip and regression use.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_bist_if.sv | 27 ++
 rtl/alu_bist_misr.sv | 40 ++++
 rtl/alu_bist.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU opcodes, MISR constants and BIST state encoding.
// Shared by the BIST sequencer, its MISR and the ALU port bundle users.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_INC  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_DEC  = 4'b0011,
    OP_MUL  = 4'b0100,
    OP_DIV  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_INV  = 4'b1010,
    OP_NAND = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_XNOR = 4'b1110,
    OP_BUF  = 4'b1111
  } alu_op_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DIS,
    S_CHK,
    S_DONE
  } bist_state_e;

endpackage

// File: rtl/alu_bist_if.sv
// ALU port bundle: operands, command and enable towards the ALU,
// combinational result back. master = BIST side, slave = ALU side.
interface alu_bist_if;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_command;
  logic        alu_enable;
  logic [15:0] alu_out;

  modport master (
    output alu_a,
    output alu_b,
    output alu_command,
    output alu_enable,
    input  alu_out
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_command,
    input  alu_enable,
    output alu_out
  );

endinterface

// File: rtl/alu_bist_misr.sv
// 16-bit MISR (poly 0x1021) with clear-to-seed, enable and data input.
// sig_d exposes the value the register takes at the coming edge.
module alu_bist_misr
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig,
  output logic [15:0] sig_d
);

  logic [15:0] sig_q;
  logic [15:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig_q[14:0], 1'b0}
            ^ (sig_q[15] ? MISR_POLY : 16'h0000)
            ^ din;
    sig_d = sig_q;
    if (clr) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = sig_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_bist.sv
// ALU BIST sequencer: exhaustive operand/command sweep into a MISR.
// Define ALU_BIST_DIRECT_CHECK_EN to add the enable-low/high check.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          OPW          = 4,
  parameter logic [15:0] EXPECTED_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  alu_bist_if.master  alu
);

  localparam int IW = 2 * OPW + 4;

  bist_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          chk_ok_q, chk_ok_d;
  logic          misr_clr;
  logic          misr_en;
  logic [15:0]   misr_sig;
  logic [15:0]   misr_d;

  alu_bist_misr u_misr (
    .clk   (clk),
    .rst   (rst),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (alu.alu_out),
    .sig   (misr_sig),
    .sig_d (misr_d)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = 8'h00;
    b_d      = 8'h00;
    cmd_d    = 4'h0;
    en_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    chk_ok_d = chk_ok_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SWEEP;
          idx_d    = '0;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          chk_ok_d = 1'b1;
          misr_clr = 1'b1;
        end
      end
      S_SWEEP: begin
        misr_en = 1'b1;
        if (idx_q == '1) begin
`ifdef ALU_BIST_DIRECT_CHECK_EN
          state_d = S_DIS;
          a_d     = 8'd20;
          b_d     = 8'd10;
          cmd_d   = OP_ADD;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_d == EXPECTED_SIG) && chk_ok_d;
`endif
        end else begin
          // idx = {a, b, cmd}: command is the fastest-moving field
          idx_d = idx_q + IW'(1);
          a_d   = 8'(idx_d[IW-1 -: OPW]);
          b_d   = 8'(idx_d[OPW+3 -: OPW]);
          cmd_d = idx_d[3:0];
          en_d  = 1'b1;
        end
      end
      S_DIS: begin
        state_d = S_CHK;
        a_d     = 8'd25;
        b_d     = 8'd17;
        cmd_d   = OP_ADD;
        en_d    = 1'b1;
      end
      S_CHK: begin
`ifdef ALU_BIST_DIRECT_CHECK_EN
        chk_ok_d = (alu.alu_out == 16'd42);
`endif
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (misr_d == EXPECTED_SIG) && chk_ok_d;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cmd_q    <= 4'h0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      chk_ok_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      chk_ok_q <= chk_ok_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign signature       = misr_sig;
  assign alu.alu_a       = a_q;
  assign alu.alu_b       = b_q;
  assign alu.alu_command = cmd_q;
  assign alu.alu_enable  = en_q;

endmodule
